// File: rtl/div_issue_ctrl.sv
// Purpose: issue/sequence control for the shared iterative divider, producing one HI/LO write per completed divide.
// Latency: accept -> ISSUE (>=1) -> divider cycles -> DONE (1); hi_we/lo_we are a one-cycle strobe.
// Backpressure: req_ready only in IDLE; holds the EX stage via busy until the divide resolves or is dropped.
module div_issue_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic        flush,
    output logic        busy,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        div_valid,
    output logic        div_signed,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic        div_tready,
    input  logic        div_complete,
    input  logic [31:0] div_s,
    input  logic [31:0] div_r,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic        sgn;
        logic [31:0] x;
        logic [31:0] y;
    } div_req_t;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] r;
    } div_res_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    div_req_t         req_q;
    div_res_t         res_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             res_ld;
    logic             accept;
    logic             cmp_ok;
    logic             wr;

    assign req_ready = resetn & (state_q == IDLE);
    assign accept    = req_valid & req_ready & ~flush;
    // The divider holds complete high while idle, so the first BUSY/DRAIN cycle cannot be trusted.
    assign cmp_ok    = div_complete & (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        res_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (req_y != 32'd0)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (div_tready) begin
                    state_d = flush ? DRAIN : BUSY;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TMO) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = cmp_ok ? IDLE : DRAIN;
                end else if (cmp_ok) begin
                    res_ld  = 1'b1;
                    state_d = DONE;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TMO) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cmp_ok) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{sgn: req_signed, x: req_x, y: req_y};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_q <= '0;
        end else if (res_ld) begin
            res_q <= '{s: div_s, r: div_r};
        end
    end

    assign div_valid  = (state_q == ISSUE);
    assign div_signed = req_q.sgn;
    assign div_x      = req_q.x;
    assign div_y      = req_q.y;

    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;

    // A late flush still has to squash the architectural write.
    assign wr       = (state_q == DONE) & ~flush;
    assign hi_we    = wr;
    assign lo_we    = wr;
    assign hi_wdata = wr ? res_q.r : 32'd0;
    assign lo_wdata = wr ? res_q.s : 32'd0;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider with settable latency/hang, scoreboard of expected HI/LO writes.
module tb_div_issue_ctrl;

    localparam int TIMEOUT = 40;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid, req_ready, req_signed, flush, busy;
    logic [31:0] req_x, req_y;
    logic        hi_we, lo_we, div_valid, div_signed, div_tready, div_complete, timeout_err;
    logic [31:0] hi_wdata, lo_wdata, div_x, div_y, div_s, div_r;

    logic        tready_en = 1'b1;
    assign div_tready = tready_en;

    div_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
        .req_x(req_x), .req_y(req_y), .flush(flush), .busy(busy),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .div_valid(div_valid), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
        .div_tready(div_tready), .div_complete(div_complete),
        .div_s(div_s), .div_r(div_r), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    int          acc_cyc = -1;
    int          bad_wdata = 0;
    int          lat = 3;
    bit          hang = 1'b0;
    int          cd = 0;
    logic [31:0] m_q, m_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic exp_t ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        if (s) begin
            e.lo = $signed(x) / $signed(y);
            e.hi = $signed(x) % $signed(y);
        end else begin
            e.lo = x / y;
            e.hi = x % y;
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Divider model: complete idles high, drops on launch, rises lat cycles later with the result.
    initial begin
        div_complete = 1'b1;
        div_s = 32'd0;
        div_r = 32'd0;
        forever begin
            @(negedge clk);
            if (div_valid && div_tready) begin
                div_complete = 1'b0;
                cd = lat;
                if (div_signed) begin
                    m_q = $signed(div_x) / $signed(div_y);
                    m_r = $signed(div_x) % $signed(div_y);
                end else begin
                    m_q = div_x / div_y;
                    m_r = div_x % div_y;
                end
            end else if (hang) begin
                div_complete = 1'b0;
            end else if (!div_complete) begin
                if (cd <= 1) begin
                    div_complete = 1'b1;
                    div_s = m_q;
                    div_r = m_r;
                end else begin
                    cd--;
                end
            end
        end
    end

    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (hi_we || lo_we) begin
                    chk("we_pair", 32'(lo_we), 32'(hi_we));
                    done_cyc = cyc;
                    if (sb.size() == 0) begin
                        chk("unexpected_write", 32'(hi_we), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("lo_wdata", lo_wdata, e.lo);
                        chk("hi_wdata", hi_wdata, e.hi);
                    end
                end else if (hi_wdata != 32'd0 || lo_wdata != 32'd0) begin
                    bad_wdata++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    task automatic send(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input bit exp_wr, input exp_t e);
        int k;
        req_valid = 1'b1;
        req_signed = s;
        req_x = x;
        req_y = y;
        k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("accept", 32'(req_ready), 32'd1);
        acc_cyc = cyc;
        if (exp_wr) sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int   k, nb, bad;
        exp_t e;
        logic s;
        logic [31:0] x, y;

        req_valid = 1'b0; req_signed = 1'b0; req_x = 32'd0; req_y = 32'd0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_div_valid", 32'(div_valid), 32'd0);
        chk("rst_hi_we", 32'(hi_we), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // DIV -7/2
        lat = 3;
        send(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
        chk("issue_valid", 32'(div_valid), 32'd1);
        chk("issue_x", div_x, 32'hFFFF_FFF9);
        chk("issue_signed", 32'(div_signed), 32'd1);
        nb = 0; k = 0;
        while (!hi_we && k < 100) begin
            if (!busy) nb++;
            @(negedge clk);
            k++;
        end
        chk("busy_through_div", 32'(nb), 32'd0);
        chk("write_seen", 32'(hi_we), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);

        // DIVU with a second request waiting behind it
        send(1'b0, 32'hFFFF_FFFF, 32'd16, 1'b1, '{hi: 32'h0000_000F, lo: 32'h0FFF_FFFF});
        send(1'b0, 32'd100, 32'd7, 1'b1, '{hi: 32'd2, lo: 32'd14});
        chk("b2b_accept_cycle", 32'(acc_cyc), 32'(done_cyc + 1));
        wait_idle();

        // divide by zero is absorbed in IDLE
        send(1'b1, 32'd123, 32'd0, 1'b0, '0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (div_valid || hi_we || !req_ready || busy) bad++;
            @(negedge clk);
        end
        chk("div0_quiet", 32'(bad), 32'd0);

        // random operands and latencies
        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom >> $urandom_range(0, 28);
            if (y == 32'd0) y = 32'd1;
            if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd3;
            lat = $urandom_range(2, 8);
            send(s, x, y, 1'b1, ref_div(s, x, y));
            wait_idle();
        end

        // flush at BUSY cnt=5 -> DRAIN until complete
        lat = 20;
        send(1'b0, 32'd1000, 32'd3, 1'b0, '0);
        @(negedge clk);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_not_ready", 32'(req_ready), 32'd0);
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain_cycles", 32'(k), 32'd14);
        chk("drain_saw_complete", 32'(div_complete), 32'd1);

        // complete and flush together: result dropped, straight to IDLE
        lat = 2;
        send(1'b1, 32'd50, 32'hFFFF_FFFA, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("cf_idle", 32'(busy), 32'd0);

        // flush while in DONE suppresses the strobes
        send(1'b0, 32'd9, 32'd4, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("in_done", 32'(hi_we), 32'd1);
        flush = 1'b1;
        #1;
        chk("done_flush_we", 32'(hi_we), 32'd0);
        chk("done_flush_data", hi_wdata, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("done_flush_idle", 32'(busy), 32'd0);

        // request arriving with flush is dropped
        req_valid = 1'b1; req_signed = 1'b0; req_x = 32'd10; req_y = 32'd5; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_req_dropped", 32'(busy), 32'd0);
        @(negedge clk);
        chk("flush_req_no_issue", 32'(div_valid), 32'd0);

        // hung divider -> timeout
        lat = 3;
        hang = 1'b1;
        send(1'b0, 32'd77, 32'd7, 1'b0, '0);
        @(negedge clk);
        repeat (TIMEOUT) @(negedge clk);
        chk("tmo_not_yet", 32'(timeout_err), 32'd0);
        chk("tmo_still_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_idle", 32'(busy), 32'd0);
        chk("tmo_ready", 32'(req_ready), 32'd1);
        hang = 1'b0;
        repeat (10) @(negedge clk);
        send(1'b0, 32'd200, 32'd9, 1'b1, ref_div(1'b0, 32'd200, 32'd9));
        wait_idle();
        chk("tmo_sticky", 32'(timeout_err), 32'd1);

        // asynchronous reset mid-BUSY
        lat = 10;
        send(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, '0);
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_div_valid", 32'(div_valid), 32'd0);
        chk("arst_hi_we", 32'(hi_we), 32'd0);
        chk("arst_err_clr", 32'(timeout_err), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            flush = (i == 4);
            if (busy || hi_we || div_valid) bad++;
        end
        flush = 1'b0;
        chk("arst_quiet", 32'(bad), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("arst_release_ready", 32'(req_ready), 32'd1);
        chk("arst_release_busy", 32'(busy), 32'd0);

        lat = 3;
        send(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
        wait_idle();
        @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("idle_wdata_zero", 32'(bad_wdata), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
